// File: rtl/mul_seq_ctrl.sv
// Sequencer for the 8-bit Acc/MQ/DR shift-add datapath: loads operands, steps the
// datapath ITER times, reads {Acc,MQ} back and returns the product over valid/ready.
module mul_seq_ctrl #(
  parameter int          WIDTH    = 8,
  parameter int          ITER     = 8,
  parameter logic [2:0]  INS_STEP = 3'b100,
  parameter logic [2:0]  INS_IDLE = 3'b000,
  parameter int          TIMEOUT  = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_prod,
  output logic                 rsp_err,
  output logic [2:0]           dp_ins,
  output logic                 dp_ld_acc,
  output logic                 dp_ld_mq,
  output logic                 dp_ld_dr,
  output logic                 dp_st_acc,
  output logic                 dp_st_mq,
  output logic                 dp_st_dr,
  output logic                 dp_testmode,
  output logic [WIDTH-1:0]     dp_in_bus,
  input  logic [WIDTH-1:0]     dp_out_bus,
  input  logic                 dp_rdy,
  output logic                 busy
);

  localparam int SW = $clog2(ITER) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(ITER - 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_DR, LD_MQ, CLR, STEP, RD_HI, RD_LO, RSP
  } state_t;

  state_t           state;
  logic [SW-1:0]    step_cnt;
  logic [TW-1:0]    stall_cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      step_cnt  <= '0;
      stall_cnt <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a    <= req_a;
            op_b    <= req_b;
            rsp_err <= 1'b0;
            state   <= LD_DR;
          end
        end
        LD_DR: state <= LD_MQ;
        LD_MQ: state <= CLR;
        CLR: begin
          step_cnt  <= '0;
          stall_cnt <= '0;
          state     <= STEP;
        end
        STEP: begin
          // stall_cnt counts consecutive not-ready cycles only; any counted step resets it
          if (dp_rdy) begin
            stall_cnt <= '0;
            step_cnt  <= step_cnt + 1'b1;
            if (step_cnt == STEP_LAST) state <= RD_HI;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_LAST) begin
              rsp_err   <= 1'b1;
              rsp_prod  <= '0;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end
          end
        end
        RD_HI: begin
          rsp_prod[2*WIDTH-1:WIDTH] <= dp_out_bus;
          state                     <= RD_LO;
        end
        RD_LO: begin
          rsp_prod[WIDTH-1:0] <= dp_out_bus;
          rsp_valid           <= 1'b1;
          state               <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dp_ins    = INS_IDLE;
    dp_ld_acc = 1'b0;
    dp_ld_mq  = 1'b0;
    dp_ld_dr  = 1'b0;
    dp_st_acc = 1'b0;
    dp_st_mq  = 1'b0;
    dp_in_bus = '0;
    case (state)
      LD_DR: begin
        dp_ld_dr  = 1'b1;
        dp_in_bus = op_a;
      end
      LD_MQ: begin
        dp_ld_mq  = 1'b1;
        dp_in_bus = op_b;
      end
      CLR:   dp_ld_acc = 1'b1;
      STEP:  dp_ins    = INS_STEP;
      RD_HI: dp_st_acc = 1'b1;
      RD_LO: dp_st_mq  = 1'b1;
      default: ;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign dp_st_dr    = 1'b0;
  assign dp_testmode = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural shift-add datapath model.
module tb_mul_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0;
  logic [7:0]  req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_prod;
  logic        rsp_err;
  logic [2:0]  dp_ins;
  logic        dp_ld_acc, dp_ld_mq, dp_ld_dr;
  logic        dp_st_acc, dp_st_mq, dp_st_dr;
  logic        dp_testmode;
  logic [7:0]  dp_in_bus;
  logic [7:0]  dp_out_bus;
  logic        dp_rdy = 1'b1;
  logic        busy;

  mul_seq_ctrl #(.WIDTH(8), .ITER(8), .INS_STEP(3'b100), .INS_IDLE(3'b000), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .dp_ins(dp_ins), .dp_ld_acc(dp_ld_acc), .dp_ld_mq(dp_ld_mq), .dp_ld_dr(dp_ld_dr),
    .dp_st_acc(dp_st_acc), .dp_st_mq(dp_st_mq), .dp_st_dr(dp_st_dr),
    .dp_testmode(dp_testmode), .dp_in_bus(dp_in_bus), .dp_out_bus(dp_out_bus),
    .dp_rdy(dp_rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath model: Acc/MQ/DR with a shift-add step
  logic [7:0]  m_acc = '0, m_mq = '0, m_dr = '0;
  logic [8:0]  m_sum;
  logic [16:0] m_sh;
  assign m_sum = {1'b0, m_acc} + (m_mq[0] ? {1'b0, m_dr} : 9'd0);
  assign m_sh  = {m_sum, m_mq} >> 1;
  assign dp_out_bus = dp_st_acc ? m_acc : (dp_st_mq ? m_mq : 8'h00);

  always @(posedge clock) begin
    if (dp_ld_dr)  m_dr  <= dp_in_bus;
    if (dp_ld_mq)  m_mq  <= dp_in_bus;
    if (dp_ld_acc) m_acc <= dp_in_bus;
    if (dp_ins == 3'b100 && dp_rdy) begin
      m_acc <= m_sh[15:8];
      m_mq  <= m_sh[7:0];
    end
  end

  // Strobe trace and per-cycle invariants
  int ev[$];
  int n_steps = 0;
  always @(negedge clock) begin
    if (reset_n) begin
      chk("ld_onehot", 32'($countones({dp_ld_dr, dp_ld_mq, dp_ld_acc}) > 1), 0);
      chk("st_onehot", 32'($countones({dp_st_acc, dp_st_mq, dp_st_dr}) > 1), 0);
      chk("testmode", dp_testmode, 0);
      chk("st_dr", dp_st_dr, 0);
      if (dp_ld_dr)  ev.push_back(256 + int'(dp_in_bus));
      if (dp_ld_mq)  ev.push_back(512 + int'(dp_in_bus));
      if (dp_ld_acc) ev.push_back(768 + int'(dp_in_bus));
      if (dp_st_acc) ev.push_back(1024);
      if (dp_st_mq)  ev.push_back(1280);
      if (dp_ins == 3'b100 && dp_rdy) n_steps++;
    end
  end

  // Scoreboard monitor
  typedef struct { logic [15:0] prod; logic err; int lat; int vcyc; } exp_t;
  exp_t sb[$];
  int   acc_cyc = 0;
  int   vcnt = 0;
  int   hs_count = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      vcnt = 0;
      sb.delete();
    end else if (rsp_valid) begin
      vcnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        if (rsp_ready) begin vcnt = 0; hs_count++; end
      end else begin
        if (vcnt == 1) chk("latency", cyc - acc_cyc, sb[0].lat);
        chk("rsp_prod", rsp_prod, sb[0].prod);
        chk("rsp_err", rsp_err, sb[0].err);
        chk("req_ready_in_rsp", req_ready, 0);
        chk("busy_in_rsp", busy, 1);
        if (rsp_ready) begin
          chk("valid_cycles", vcnt, sb[0].vcyc);
          void'(sb.pop_front());
          vcnt = 0;
          hs_count++;
        end
      end
    end
  end

  int ev_base;
  int step_base;
  int hs_base;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                       input logic e, input int lat, input int vc);
    bit ok;
    ok = 0;
    @(posedge clock); #1;
    req_a = a; req_b = b; req_valid = 1'b1;
    ev_base = ev.size(); step_base = n_steps; hs_base = hs_count;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin
        acc_cyc = cyc + 1;
        sb.push_back('{prod: p, err: e, lat: lat, vcyc: vc});
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (hs_count != hs_base) begin ok = 1; break; end
    end
    chk("rsp_timeout", ok, 1);
    @(posedge clock); #1;
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic wait_steps(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (n_steps - step_base >= n) begin ok = 1; break; end
    end
    chk("step_wait_timeout", ok, 1);
  endtask

  task automatic check_trace(input logic [7:0] a, input logic [7:0] b, input bit full);
    int exp_ev[$];
    int got;
    exp_ev.push_back(256 + int'(a));
    exp_ev.push_back(512 + int'(b));
    exp_ev.push_back(768);
    if (full) begin
      exp_ev.push_back(1024);
      exp_ev.push_back(1280);
    end
    got = ev.size() - ev_base;
    chk("ev_count", got, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got; i++)
      chk("ev_order", ev[ev_base + i], exp_ev[i]);
    chk("step_count", n_steps - step_base, full ? 8 : 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_prod", rsp_prod, 0);
    chk("rst_dp_ins", dp_ins, 0);
    chk("rst_dp_in_bus", dp_in_bus, 0);
    chk("rst_strobes", {dp_ld_acc, dp_ld_mq, dp_ld_dr, dp_st_acc, dp_st_mq, dp_st_dr}, 0);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;
  vec_t vecs[5] = '{
    '{a: 8'h05, b: 8'h03, p: 16'h000F},
    '{a: 8'hFF, b: 8'h01, p: 16'h00FF},
    '{a: 8'h80, b: 8'h02, p: 16'h0100},
    '{a: 8'h00, b: 8'hFF, p: 16'h0000},
    '{a: 8'hA5, b: 8'h3C, p: 16'h26AC}
  };

  initial begin
    int cnt;
    reset_n = 1'b0;
    #12;
    check_reset_outputs();
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_dp_ins", dp_ins, 0);
      chk("idle_strobes", {dp_ld_acc, dp_ld_mq, dp_ld_dr, dp_st_acc, dp_st_mq, dp_st_dr}, 0);
    end

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, 13, 1);
      wait_rsp();
      check_trace(vecs[i].a, vecs[i].b, 1'b1);
    end

    // Backpressure: response held for 6 cycles
    rsp_ready = 1'b0;
    issue(8'h05, 8'h03, 16'h000F, 1'b0, 13, 6);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 5; i++) begin
      @(negedge clock);
      if (rsp_valid) cnt++;
    end
    chk("bp_valid_seen", cnt, 5);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_rsp();
    check_trace(8'h05, 8'h03, 1'b1);

    // dp_rdy stall of 4 cycles in the middle of STEP
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b0, 17, 1);
    wait_steps(3);
    @(posedge clock); #1;
    dp_rdy = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    dp_rdy = 1'b1;
    wait_rsp();
    check_trace(8'hFF, 8'hFF, 1'b1);

    // Timeout: dp_rdy never rises in STEP
    dp_rdy = 1'b0;
    issue(8'h12, 8'h34, 16'h0000, 1'b1, 18, 1);
    wait_rsp();
    check_trace(8'h12, 8'h34, 1'b0);
    dp_rdy = 1'b1;

    // Asynchronous reset in the middle of STEP, then a clean transaction
    issue(8'h07, 8'h09, 16'h003F, 1'b0, 13, 1);
    wait_steps(3);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clock); #1;
    reset_n = 1'b1;
    issue(8'h0C, 8'h0A, 16'h0078, 1'b0, 13, 1);
    wait_rsp();
    check_trace(8'h0C, 8'h0A, 1'b1);

    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Sequencer for the 8-bit Acc/MQ/DR shift-add ALU datapath. It accepts multiply requests over a valid/ready port, loads the operands into DR and MQ, and clears Acc. It then steps the datapath ITER times, reads back Acc (high half) and MQ (low half) over the shared output bus, and returns the product over a valid/ready response port. It is the only master of the datapath control inputs, and TESTMODE is always held low.

Parameters:
WIDTH, 8, datapath/operand width
ITER, 8, number of multiply step cycles (must equal WIDTH for a full product)
INS_STEP, 3'b100, instruction code driven on dp_ins during step cycles
INS_IDLE, 3'b000, instruction code driven in all other states
TIMEOUT, 15, consecutive dp_rdy-low cycles in STEP before abort (>=1)

Ports:
clock  in  1  single clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_a  in  WIDTH  multiplicand (loaded into DR)
req_b  in  WIDTH  multiplier (loaded into MQ)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_prod  out  2*WIDTH  product {Acc,MQ}
rsp_err  out  1  1 = aborted on timeout, rsp_prod is 0
dp_ins  out  3  datapath INS
dp_ld_acc, dp_ld_mq, dp_ld_dr  out  1 each  datapath load strobes
dp_st_acc, dp_st_mq, dp_st_dr  out  1 each  datapath bus-drive selects
dp_testmode  out  1  constant 0
dp_in_bus  out  WIDTH  datapath inBUS
dp_out_bus  in  WIDTH  datapath outBUS (combinational from registers)
dp_rdy  in  1  datapath RDY; a step counts only when high
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, step_cnt=0, stall_cnt=0, rsp_valid=0, rsp_err=0, rsp_prod=0, operand regs=0. Every strobe/select=0, dp_ins=INS_IDLE, dp_in_bus=0, req_ready=1, busy=0.
- States: IDLE, LD_DR, LD_MQ, CLR, STEP, RD_HI, RD_LO, RSP. All datapath outputs are decoded combinationally from the state and registered operands. In each state, at most one dp_ld_* and at most one dp_st_* is high.
- IDLE: req_ready=1. On req_valid=1, capture req_a/req_b, clear rsp_err, and go to LD_DR. With req_valid=0, remain in IDLE with all strobes low.
- LD_DR: dp_ld_dr=1, dp_in_bus=a. Go to LD_MQ.
- LD_MQ: dp_ld_mq=1, dp_in_bus=b. Go to CLR.
- CLR: dp_ld_acc=1, dp_in_bus=0. Go to STEP with step_cnt=0 and stall_cnt=0.
- STEP: dp_ins=INS_STEP.
  - dp_rdy=1: step_cnt++, stall_cnt=0. If step_cnt==ITER-1, go to RD_HI.
  - dp_rdy=0: step_cnt holds, stall_cnt++. If stall_cnt==TIMEOUT-1, go to RSP with rsp_err=1 and rsp_prod=0.
- RD_HI: dp_st_acc=1. Register dp_out_bus into rsp_prod[2W-1:W]. Go to RD_LO.
- RD_LO: dp_st_mq=1. Register dp_out_bus into rsp_prod[W-1:0]. Set rsp_valid=1 and go to RSP.
- RSP: rsp_valid=1 and rsp_prod/rsp_err held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, clear rsp_valid at the edge and go to IDLE.
  - rsp_ready sampled high in RSP's first cycle is honoured, so RSP lasts 1 cycle.
- Latency, with dp_rdy held 1 and measured from the accepting edge: rsp_valid is high after edge ITER+5 (13 for defaults).
- req_ready=0 in every state except IDLE, and req_valid outside IDLE is ignored. A new request is accepted no earlier than the cycle after the response handshake, so there is no overlap.
- dp_testmode=0 and dp_st_dr=0 in all states.
- step_cnt width is clog2(ITER)+1 and never wraps. stall_cnt width is clog2(TIMEOUT)+1 and saturates irrelevantly, since it exits at TIMEOUT-1.
- reset_n low mid-operation: immediate return to reset values. The datapath registers are not cleared by this block; the next request reloads DR/MQ/Acc.

Test Plan:
- Reset then idle: reset_n pulse, req_valid=0 for 10 cycles -> req_ready=1, busy=0, all dp_ld_*/dp_st_*=0, dp_ins=000, rsp_valid=0.
- Single request a=0x05, b=0x03, dp_rdy=1, bench model returns Acc=0x00 and MQ=0x0F on out_bus -> strobes in order DR(0x05), MQ(0x03), ACC(0x00), then 8 INS_STEP cycles, st_acc, st_mq; rsp_valid after edge 13, rsp_prod=0x000F, rsp_err=0.
- Backpressure: same transaction with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_prod stable for 6 cycles, req_ready=0 throughout; IDLE the cycle after the handshake.
- dp_rdy stall: dp_rdy=0 for 4 cycles mid-STEP with 0xFF*0xFF (model Acc=0xFE, MQ=0x01) -> exactly 8 counted steps, rsp_prod=0xFE01, latency 17.
- Timeout: dp_rdy stuck 0 on entering STEP -> RSP after exactly 15 STEP cycles, rsp_err=1, rsp_prod=0x0000, no st_acc/st_mq strobe.
- Reset mid-STEP: reset_n=0 after 3 steps -> outputs at reset values asynchronously; next request completes normally with rsp_err=0 and correct product.
